// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - fetch-stage sequencer: PC, stalls, redirects, halt drain
//
// Purpose: owns the program counter feeding instruction_memory, applies hazard
// stalls and branch redirects, drives IF/ID write-enable/flush, and parks the
// core after a HALT instruction has drained through the pipeline.
//
// Ports:
//   clk            in   1   system clock, rising edge
//   reset          in   1   synchronous, active-high
//   hz_stall       in   1   hazard unit requests IF hold
//   br_taken       in   1   taken branch/jump resolved this cycle
//   br_target      in   16  redirect address (LSB forced to 0)
//   if_instruction in   16  instruction at if_from_pc
//   if_from_pc     out  16  registered PC
//   ifid_we        out  1   IF/ID captures {pc+2, if_instruction}
//   ifid_flush     out  1   IF/ID loads a bubble; overrides ifid_we
//   halted         out  1   core is parked
//   fetch_count    out  16  accepted fetches, saturating
module fetch_controller #(
   parameter logic [15:0] RESET_PC     = 16'h0000,
   parameter logic [3:0]  HALT_OPCODE  = 4'hF,
   parameter int          DRAIN_CYCLES = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        hz_stall,
   input  logic        br_taken,
   input  logic [15:0] br_target,
   input  logic [15:0] if_instruction,
   output logic [15:0] if_from_pc,
   output logic        ifid_we,
   output logic        ifid_flush,
   output logic        halted,
   output logic [15:0] fetch_count
);

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2,
      HALT  = 2'd3
   } state_t;

   state_t      state, state_next;
   logic [15:0] pc_next;
   logic [3:0]  drain_cnt, drain_next;
   logic        halted_next;
   logic        accept;

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= BOOT;
         if_from_pc  <= RESET_PC;
         halted      <= 1'b0;
         fetch_count <= 16'h0000;
         drain_cnt   <= 4'd0;
      end else begin
         state      <= state_next;
         if_from_pc <= pc_next;
         halted     <= halted_next;
         drain_cnt  <= drain_next;
         if (accept && fetch_count != 16'hFFFF)
            fetch_count <= fetch_count + 16'd1;
      end
   end

   assign accept = ifid_we && !ifid_flush;

   always_comb begin
      state_next  = state;
      pc_next     = if_from_pc;
      drain_next  = drain_cnt;
      halted_next = halted;
      ifid_we     = 1'b0;
      ifid_flush  = 1'b0;

      case (state)
         BOOT: begin
            ifid_flush = 1'b1;
            state_next = RUN;
         end

         RUN: begin
            if (br_taken) begin
               pc_next    = {br_target[15:1], 1'b0};
               ifid_flush = 1'b1;
            end else if (!hz_stall) begin
               ifid_we = 1'b1;
               if (if_instruction[15:12] == HALT_OPCODE) begin
                  // PC stays on the halt so nothing younger is fetched.
                  drain_next = 4'(DRAIN_CYCLES);
                  state_next = DRAIN;
               end else begin
                  pc_next = if_from_pc + 16'd2;
               end
            end
         end

         DRAIN: begin
            if (br_taken) begin
               // An older branch resolved behind the halt: cancel the halt.
               pc_next    = {br_target[15:1], 1'b0};
               ifid_flush = 1'b1;
               drain_next = 4'd0;
               state_next = RUN;
            end else if (!hz_stall) begin
               // Bubbles only once IF/ID is free to advance past the halt.
               ifid_flush = 1'b1;
               drain_next = drain_cnt - 4'd1;
               if (drain_cnt == 4'd1) begin
                  state_next  = HALT;
                  halted_next = 1'b1;
               end
            end
         end

         HALT: begin
            ifid_flush = 1'b1;
         end

         default: begin
            state_next = BOOT;
         end
      endcase
   end

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - directed self-checking bench for fetch_controller
module tb_fetch_controller;

   logic        clk = 1'b0;
   logic        reset;
   logic        hz_stall;
   logic        br_taken;
   logic [15:0] br_target;
   logic [15:0] if_instruction;
   logic [15:0] if_from_pc;
   logic        ifid_we;
   logic        ifid_flush;
   logic        halted;
   logic [15:0] fetch_count;
   logic [15:0] halt_addr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   // Instruction memory model: NOP everywhere except a HALT word at halt_addr.
   assign if_instruction = (if_from_pc == halt_addr) ? 16'hF000 : 16'h0000;

   fetch_controller #(
      .RESET_PC(16'h0000),
      .HALT_OPCODE(4'hF),
      .DRAIN_CYCLES(4)
   ) dut (
      .clk(clk),
      .reset(reset),
      .hz_stall(hz_stall),
      .br_taken(br_taken),
      .br_target(br_target),
      .if_instruction(if_instruction),
      .if_from_pc(if_from_pc),
      .ifid_we(ifid_we),
      .ifid_flush(ifid_flush),
      .halted(halted),
      .fetch_count(fetch_count)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; hz_stall = 1'b0; br_taken = 1'b0; br_target = 16'h0000;
      halt_addr = 16'hFFFF;
      cyc(); cyc();
      check("rst_pc", 32'(if_from_pc), 32'h0000);
      check("rst_halted", 32'(halted), 32'h0);
      check("rst_count", 32'(fetch_count), 32'h0000);
      reset = 1'b0;
      #1;
      check("boot_flush", 32'(ifid_flush), 32'h1);
      check("boot_we", 32'(ifid_we), 32'h0);
      cyc();
      check("run_pc0", 32'(if_from_pc), 32'h0000);
      check("run_we", 32'(ifid_we), 32'h1);
      cyc();
      check("run_pc2", 32'(if_from_pc), 32'h0002);
      cyc();
      check("run_pc4", 32'(if_from_pc), 32'h0004);

      // Two stall cycles at 0x0004.
      hz_stall = 1'b1;
      #1;
      check("stall_we", 32'(ifid_we), 32'h0);
      check("stall_flush", 32'(ifid_flush), 32'h0);
      cyc(); cyc();
      check("stall_pc", 32'(if_from_pc), 32'h0004);
      check("stall_count", 32'(fetch_count), 32'd2);
      hz_stall = 1'b0;
      cyc();
      check("resume_pc", 32'(if_from_pc), 32'h0006);
      cyc();
      check("run_pc8", 32'(if_from_pc), 32'h0008);
      check("run_count4", 32'(fetch_count), 32'd4);

      // Branch and stall together: branch wins, LSB forced to 0.
      br_taken = 1'b1; br_target = 16'h0031; hz_stall = 1'b1;
      #1;
      check("brst_flush", 32'(ifid_flush), 32'h1);
      check("brst_we", 32'(ifid_we), 32'h0);
      cyc();
      check("brst_pc", 32'(if_from_pc), 32'h0030);
      check("brst_count", 32'(fetch_count), 32'd4);
      hz_stall = 1'b0;

      // PC wrap from 0xFFFE.
      br_target = 16'hFFFF;
      cyc();
      check("wrap_pre", 32'(if_from_pc), 32'hFFFE);
      br_taken = 1'b0;
      cyc();
      check("wrap_pc", 32'(if_from_pc), 32'h0000);
      check("wrap_count", 32'(fetch_count), 32'd5);

      // Halt at 0x0010 with a clean drain.
      halt_addr = 16'h0010;
      br_taken = 1'b1; br_target = 16'h0010;
      cyc();
      br_taken = 1'b0;
      #1;
      check("halt_accept_we", 32'(ifid_we), 32'h1);
      check("halt_accept_flush", 32'(ifid_flush), 32'h0);
      cyc();
      check("halt_count", 32'(fetch_count), 32'd6);
      check("halt_pc_held", 32'(if_from_pc), 32'h0010);
      for (int i = 0; i < 3; i++) begin
         check("drain_flush", 32'(ifid_flush), 32'h1);
         cyc();
         check("drain_pc", 32'(if_from_pc), 32'h0010);
         check("drain_not_halted", 32'(halted), 32'h0);
      end
      check("drain_last_flush", 32'(ifid_flush), 32'h1);
      cyc();
      check("halted_set", 32'(halted), 32'h1);
      check("halted_pc", 32'(if_from_pc), 32'h0010);
      br_taken = 1'b1; br_target = 16'h0200; hz_stall = 1'b1;
      #1;
      check("halt_flush", 32'(ifid_flush), 32'h1);
      check("halt_we", 32'(ifid_we), 32'h0);
      cyc();
      check("halt_ign_pc", 32'(if_from_pc), 32'h0010);
      check("halt_ign_halted", 32'(halted), 32'h1);
      check("halt_ign_count", 32'(fetch_count), 32'd6);
      br_taken = 1'b0; hz_stall = 1'b0;

      // Reset while parked.
      reset = 1'b1;
      cyc();
      check("rst2_pc", 32'(if_from_pc), 32'h0000);
      check("rst2_halted", 32'(halted), 32'h0);
      check("rst2_count", 32'(fetch_count), 32'h0000);
      reset = 1'b0;
      #1;
      check("rst2_boot_flush", 32'(ifid_flush), 32'h1);
      check("rst2_boot_we", 32'(ifid_we), 32'h0);
      cyc();
      check("rst2_run_pc", 32'(if_from_pc), 32'h0000);

      // Halt cancelled by an older branch after a stalled drain cycle.
      br_taken = 1'b1; br_target = 16'h0010;
      cyc();
      br_taken = 1'b0;
      cyc();
      check("cancel_count", 32'(fetch_count), 32'd1);
      hz_stall = 1'b1;
      #1;
      check("cancel_stall_flush", 32'(ifid_flush), 32'h0);
      check("cancel_stall_we", 32'(ifid_we), 32'h0);
      cyc();
      hz_stall = 1'b0; br_taken = 1'b1; br_target = 16'h0100;
      #1;
      check("cancel_br_flush", 32'(ifid_flush), 32'h1);
      cyc();
      br_taken = 1'b0;
      check("cancel_pc", 32'(if_from_pc), 32'h0100);
      check("cancel_halted", 32'(halted), 32'h0);
      #1;
      check("cancel_run_we", 32'(ifid_we), 32'h1);
      cyc();
      check("cancel_next_pc", 32'(if_from_pc), 32'h0102);
      check("cancel_count2", 32'(fetch_count), 32'd2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
